// File: rtl/parry_event_tracker.sv
// Purpose: reduces per-pixel collision/touch flags to per-frame parry and touch events with score and cooldown.
// Latency: parry_out/touch_out/score/state update one cycle after the new_frame_in rising edge.
// Backpressure: none; inputs are sampled every pixel cycle and events are fire-and-forget pulses.
module parry_event_tracker #(
  parameter int CONFIRM_FRAMES  = 2,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int SCORE_WIDTH     = 4,
  parameter int MAX_SCORE       = 5
) (
  input  logic                   clk_pixel_in,
  input  logic                   rst_in,
  input  logic                   new_frame_in,
  input  logic                   is_colliding,
  input  logic                   touch_in,
  output logic                   parry_out,
  output logic                   touch_out,
  output logic [SCORE_WIDTH-1:0] score_out,
  output logic                   lockout_out,
  output logic                   game_over_out,
  output logic [1:0]             state_out
);

  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [CW-1:0]          CONF_TGT = CW'(CONFIRM_FRAMES);
  localparam logic [7:0]             CD_LOAD  = 8'(COOLDOWN_FRAMES);
  localparam logic [SCORE_WIDTH-1:0] MAX_S    = SCORE_WIDTH'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONFIRM   = 2'd1,
    COOLDOWN  = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          conf_cnt, conf_nxt, conf_step;
  logic [7:0]             cd_cnt, cd_nxt;
  logic [SCORE_WIDTH-1:0] score, score_nxt, score_inc;
  logic                   parry_q, parry_nxt;
  logic                   touch_q, touch_nxt;
  logic                   nf_prev;
  logic                   coll_flag, touch_flag;
  logic                   boundary;
  logic                   frame_coll, frame_touch;

  // A held new_frame_in counts once: only its rising edge is a boundary.
  assign boundary = new_frame_in & ~nf_prev;

  // Inputs in the boundary cycle itself belong to the frame that is closing.
  assign frame_coll  = coll_flag  | is_colliding;
  assign frame_touch = touch_flag | touch_in;

  // State, counters, per-frame flags and registered event pulses; reset overrides everything.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state      <= IDLE;
      conf_cnt   <= '0;
      cd_cnt     <= '0;
      score      <= '0;
      parry_q    <= 1'b0;
      touch_q    <= 1'b0;
      nf_prev    <= 1'b0;
      coll_flag  <= 1'b0;
      touch_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      conf_cnt   <= conf_nxt;
      cd_cnt     <= cd_nxt;
      score      <= score_nxt;
      parry_q    <= parry_nxt;
      touch_q    <= touch_nxt;
      nf_prev    <= new_frame_in;
      coll_flag  <= boundary ? 1'b0 : frame_coll;
      touch_flag <= boundary ? 1'b0 : frame_touch;
    end
  end

  // Boundary evaluation: parry path has priority over touch; cooldown ignores frame results.
  always_comb begin
    state_nxt = state;
    conf_nxt  = conf_cnt;
    cd_nxt    = cd_cnt;
    score_nxt = score;
    parry_nxt = 1'b0;
    touch_nxt = 1'b0;
    conf_step = (state == IDLE) ? CW'(1) : conf_cnt + CW'(1);
    score_inc = score + SCORE_WIDTH'(1);
    if (boundary) begin
      case (state)
        IDLE, CONFIRM: begin
          if (frame_coll) begin
            if (conf_step == CONF_TGT) begin
              parry_nxt = 1'b1;
              conf_nxt  = '0;
              cd_nxt    = CD_LOAD;
              state_nxt = COOLDOWN;
            end else begin
              conf_nxt  = conf_step;
              state_nxt = CONFIRM;
            end
          end else begin
            conf_nxt = '0;
            if (frame_touch && (score < MAX_S)) begin
              touch_nxt = 1'b1;
              score_nxt = score_inc;
              if (score_inc == MAX_S) begin
                state_nxt = GAME_OVER;
              end else begin
                cd_nxt    = CD_LOAD;
                state_nxt = COOLDOWN;
              end
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        COOLDOWN: begin
          if (cd_cnt <= 8'd1) begin
            cd_nxt    = 8'd0;
            state_nxt = IDLE;
          end else begin
            cd_nxt = cd_cnt - 8'd1;
          end
        end
        GAME_OVER: begin
          state_nxt = GAME_OVER;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign parry_out     = parry_q;
  assign touch_out     = touch_q;
  assign score_out     = score;
  assign lockout_out   = (state == COOLDOWN) || (state == GAME_OVER);
  assign game_over_out = (state == GAME_OVER);
  assign state_out     = state;

endmodule

// File: tb/tb_parry_event_tracker.sv
// Purpose: directed bench for parry_event_tracker with an expected-result queue checked after each boundary.
// Latency: each frame is 6 body cycles plus a boundary; results are checked the cycle after the boundary.
// Backpressure: none; pulses are also counted continuously and totalled at the end.
module tb_parry_event_tracker;

  logic       clk_pixel_in = 1'b0;
  logic       rst_in       = 1'b1;
  logic       new_frame_in = 1'b0;
  logic       is_colliding = 1'b0;
  logic       touch_in     = 1'b0;
  logic       parry_out;
  logic       touch_out;
  logic [3:0] score_out;
  logic       lockout_out;
  logic       game_over_out;
  logic [1:0] state_out;

  parry_event_tracker dut (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .new_frame_in (new_frame_in),
    .is_colliding (is_colliding),
    .touch_in     (touch_in),
    .parry_out    (parry_out),
    .touch_out    (touch_out),
    .score_out    (score_out),
    .lockout_out  (lockout_out),
    .game_over_out(game_over_out),
    .state_out    (state_out)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  typedef struct packed {
    logic       parry;
    logic       touch;
    logic [3:0] score;
    logic [1:0] state;
    logic       lock;
    logic       go;
  } want_t;

  want_t want_q[$];
  int    errors = 0;
  int    checks = 0;
  int    want_parry_cnt = 0;
  int    want_touch_cnt = 0;
  int    obs_parry_cnt = 0;
  int    obs_touch_cnt = 0;
  int    obs_both_cnt = 0;

  // Continuous pulse tally, independent of the per-boundary checks.
  always @(negedge clk_pixel_in) begin
    if (parry_out === 1'b1) obs_parry_cnt++;
    if (touch_out === 1'b1) obs_touch_cnt++;
    if ((parry_out === 1'b1) && (touch_out === 1'b1)) obs_both_cnt++;
  end

  function automatic want_t mk(input logic p, input logic t, input int sc, input int st,
                               input logic lk, input logic go);
    want_t w;
    w.parry = p;
    w.touch = t;
    w.score = 4'(sc);
    w.state = 2'(st);
    w.lock  = lk;
    w.go    = go;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_want(input want_t w);
    want_q.push_back(w);
    want_parry_cnt += int'(w.parry);
    want_touch_cnt += int'(w.touch);
  endtask

  task automatic check_out(input string tag);
    want_t w;
    checks++;
    assert (want_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end
    if (want_q.size() > 0) begin
      w = want_q.pop_front();
      chk({tag, "_parry"}, 32'(parry_out),     32'(w.parry));
      chk({tag, "_touch"}, 32'(touch_out),     32'(w.touch));
      chk({tag, "_score"}, 32'(score_out),     32'(w.score));
      chk({tag, "_state"}, 32'(state_out),     32'(w.state));
      chk({tag, "_lock"},  32'(lockout_out),   32'(w.lock));
      chk({tag, "_go"},    32'(game_over_out), 32'(w.go));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_pixel_in);
    rst_in = 1'b1; new_frame_in = 1'b0; is_colliding = 1'b0; touch_in = 1'b0;
    @(negedge clk_pixel_in);
    rst_in = 1'b0;
    push_want(mk(0, 0, 0, 0, 0, 0));
    check_out(tag);
  endtask

  // One frame: 6 body cycles, a boundary held for 'hold' cycles, then a check.
  task automatic frame(input string tag, input logic c_mid, input logic t_mid,
                       input logic c_bnd, input logic t_bnd, input int hold, input want_t w);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_pixel_in);
      new_frame_in = 1'b0;
      is_colliding = c_mid;
      touch_in     = t_mid && (i == 3);
    end
    @(negedge clk_pixel_in);
    new_frame_in = 1'b1; is_colliding = c_bnd; touch_in = t_bnd;
    push_want(w);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk_pixel_in);
      is_colliding = 1'b0; touch_in = 1'b0;
    end
    @(negedge clk_pixel_in);
    new_frame_in = 1'b0; is_colliding = 1'b0; touch_in = 1'b0;
    check_out(tag);
  endtask

  initial begin
    do_reset("rst0");

    // Three full collision frames: confirm, parry, stay in cooldown.
    frame("t1_f1", 1, 0, 1, 0, 1, mk(0, 0, 0, 1, 0, 0));
    frame("t1_f2", 1, 0, 1, 0, 1, mk(1, 0, 0, 2, 1, 0));
    frame("t1_f3", 1, 0, 1, 0, 1, mk(0, 0, 0, 2, 1, 0));

    // Single collision frame then a clean frame: no parry, back to idle.
    do_reset("rst2");
    frame("t2_f1", 1, 0, 1, 0, 1, mk(0, 0, 0, 1, 0, 0));
    frame("t2_f2", 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));

    // One-cycle touch, then exactly 30 cooldown boundaries.
    do_reset("rst3");
    frame("t3_touch", 0, 1, 0, 0, 1, mk(0, 1, 1, 2, 1, 0));
    for (int k = 1; k <= 30; k++)
      frame("t3_cd", 0, 0, 0, 0, 1, mk(0, 0, 1, (k == 30) ? 0 : 2, k < 30, 0));
    frame("t3_idle", 0, 0, 0, 0, 1, mk(0, 0, 1, 0, 0, 0));

    // Collision and touch in the same frame: parry path wins, touch discarded.
    do_reset("rst4");
    frame("t4_f1", 1, 1, 1, 0, 1, mk(0, 0, 0, 1, 0, 0));
    frame("t4_f2", 1, 0, 1, 0, 1, mk(1, 0, 0, 2, 1, 0));

    // Held boundary counts once: stays in CONFIRM, then the next frame parries.
    do_reset("rst4h");
    frame("hold_f1", 1, 0, 1, 0, 3, mk(0, 0, 0, 1, 0, 0));
    frame("hold_f2", 1, 0, 1, 0, 1, mk(1, 0, 0, 2, 1, 0));

    // Five spaced touches end the bout; later activity produces nothing.
    do_reset("rst5");
    for (int i = 1; i <= 5; i++) begin
      frame("t5_touch", 0, 1, 0, 0, 1, mk(0, 1, i, (i == 5) ? 3 : 2, 1, i == 5));
      if (i < 5)
        for (int k = 1; k <= 30; k++)
          frame("t5_cd", 0, 0, 0, 0, 1, mk(0, 0, i, (k == 30) ? 0 : 2, k < 30, 0));
    end
    frame("t5_over_t", 0, 1, 0, 0, 1, mk(0, 0, 5, 3, 1, 1));
    frame("t5_over_c", 1, 0, 1, 0, 1, mk(0, 0, 5, 3, 1, 1));

    // Touch only in the boundary cycle counts for the closing frame.
    do_reset("rst6");
    frame("t6_bnd", 0, 0, 0, 1, 1, mk(0, 1, 1, 2, 1, 0));

    // Reset coinciding with that boundary suppresses the touch.
    do_reset("rst6b");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_pixel_in);
      new_frame_in = 1'b0; is_colliding = 1'b0; touch_in = 1'b0;
    end
    @(negedge clk_pixel_in);
    new_frame_in = 1'b1; touch_in = 1'b1; rst_in = 1'b1;
    push_want(mk(0, 0, 0, 0, 0, 0));
    @(negedge clk_pixel_in);
    new_frame_in = 1'b0; touch_in = 1'b0; rst_in = 1'b0;
    check_out("t6_rst");
    frame("t6_after", 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));

    @(negedge clk_pixel_in);
    chk("parry_pulses", 32'(obs_parry_cnt), 32'(want_parry_cnt));
    chk("touch_pulses", 32'(obs_touch_cnt), 32'(want_touch_cnt));
    chk("both_pulses",  32'(obs_both_cnt),  32'd0);
    chk("queue_left",   32'(want_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
